// File: rtl/core_pkg.sv
// Shared lane types for the vector register file datapath.
package core_pkg;

  parameter int unsigned VrfDataWidth = 64;
  parameter int unsigned VrfAddrWidth = 10;
  parameter int unsigned InsnIdWidth  = 3;

  typedef logic [VrfDataWidth-1:0]   vrf_data_t;
  typedef logic [VrfDataWidth/8-1:0] vrf_strb_t;
  typedef logic [VrfAddrWidth-1:0]   vrf_addr_t;
  typedef logic [InsnIdWidth-1:0]    insn_id_t;

endpackage

// File: rtl/vrf_write_arbiter.sv
// Lane VRF write-back arbiter: per-bank round-robin grant over VFU result writes,
// one registered write stage into the banked SRAM, plus per-requester write ack.
module vrf_write_arbiter
  import core_pkg::*;
#(
  parameter int unsigned NrReq  = 4,
  parameter int unsigned NrBank = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic      [NrReq-1:0]  req_valid_i,
  output logic      [NrReq-1:0]  req_gnt_o,
  input  vrf_data_t [NrReq-1:0]  req_wdata_i,
  input  vrf_strb_t [NrReq-1:0]  req_wstrb_i,
  input  vrf_addr_t [NrReq-1:0]  req_addr_i,
  input  insn_id_t  [NrReq-1:0]  req_id_i,
  input  logic      [NrBank-1:0] bank_rd_busy_i,
  output logic      [NrBank-1:0] bank_we_o,
  output vrf_addr_t [NrBank-1:0] bank_addr_o,
  output vrf_data_t [NrBank-1:0] bank_wdata_o,
  output vrf_strb_t [NrBank-1:0] bank_wstrb_o,
  output logic      [NrReq-1:0]  wr_ack_o,
  output insn_id_t  [NrReq-1:0]  wr_ack_id_o
);

  localparam int unsigned LogNrBank = $clog2(NrBank);
  localparam int unsigned LogNrReq  = $clog2(NrReq);

  typedef logic [LogNrReq-1:0] req_idx_t;

  req_idx_t  [NrBank-1:0] rr_q, rr_d;
  req_idx_t  [NrBank-1:0] win_idx;
  logic      [NrBank-1:0] win_valid;

  logic      [NrBank-1:0] we_q;
  vrf_addr_t [NrBank-1:0] addr_q, addr_d;
  vrf_data_t [NrBank-1:0] wdata_q, wdata_d;
  vrf_strb_t [NrBank-1:0] wstrb_q, wstrb_d;

  logic      [NrReq-1:0]  ack_q;
  insn_id_t  [NrReq-1:0]  ack_id_q, ack_id_d;

  // Per bank: first candidate at or after rr_q scanning upward; NrReq is a power of
  // two so the index wraps by truncation.
  always_comb begin
    req_idx_t idx;
    idx       = '0;
    win_valid = '0;
    win_idx   = '0;
    req_gnt_o = '0;
    rr_d      = rr_q;
    for (int b = 0; b < NrBank; b++) begin
      if (!bank_rd_busy_i[b]) begin
        for (int i = 0; i < NrReq; i++) begin
          idx = rr_q[b] + req_idx_t'(i);
          if (!win_valid[b] && req_valid_i[idx] &&
              (req_addr_i[idx][LogNrBank-1:0] == LogNrBank'(b))) begin
            win_valid[b] = 1'b1;
            win_idx[b]   = idx;
          end
        end
      end
      if (win_valid[b]) begin
        req_gnt_o[win_idx[b]] = 1'b1;
        rr_d[b]               = win_idx[b] + req_idx_t'(1);
      end
    end
  end

  // Stage payload reloads every cycle; zeroed when the bank has no grant.
  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    wstrb_d = '0;
    for (int b = 0; b < NrBank; b++) begin
      if (win_valid[b]) begin
        addr_d[b]  = req_addr_i[win_idx[b]] >> LogNrBank;
        wdata_d[b] = req_wdata_i[win_idx[b]];
        wstrb_d[b] = req_wstrb_i[win_idx[b]];
      end
    end
  end

  always_comb begin
    ack_id_d = '0;
    for (int r = 0; r < NrReq; r++) begin
      if (req_gnt_o[r]) begin
        ack_id_d[r] = req_id_i[r];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      ack_q    <= '0;
      ack_id_q <= '0;
    end else begin
      rr_q     <= rr_d;
      we_q     <= win_valid;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      ack_q    <= req_gnt_o;
      ack_id_q <= ack_id_d;
    end
  end

  assign bank_we_o    = we_q;
  assign bank_addr_o  = addr_q;
  assign bank_wdata_o = wdata_q;
  assign bank_wstrb_o = wstrb_q;
  assign wr_ack_o     = ack_q;
  assign wr_ack_id_o  = ack_id_q;

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Bench for vrf_write_arbiter: per-scenario tasks check grants inline; a scoreboard
// queue of expected SRAM writes is checked against the bank ports and acks.
module tb_vrf_write_arbiter;
  import core_pkg::*;

  localparam int unsigned NrReq  = 4;
  localparam int unsigned NrBank = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic      [NrReq-1:0]  req_valid = '0;
  logic      [NrReq-1:0]  req_gnt;
  vrf_data_t [NrReq-1:0]  req_wdata = '0;
  vrf_strb_t [NrReq-1:0]  req_wstrb = '0;
  vrf_addr_t [NrReq-1:0]  req_addr = '0;
  insn_id_t  [NrReq-1:0]  req_id = '0;
  logic      [NrBank-1:0] bank_rd_busy = '0;
  logic      [NrBank-1:0] bank_we;
  vrf_addr_t [NrBank-1:0] bank_addr;
  vrf_data_t [NrBank-1:0] bank_wdata;
  vrf_strb_t [NrBank-1:0] bank_wstrb;
  logic      [NrReq-1:0]  wr_ack;
  insn_id_t  [NrReq-1:0]  wr_ack_id;

  typedef struct {
    int unsigned cyc;
    int unsigned bank;
    vrf_addr_t   row;
    vrf_data_t   data;
    vrf_strb_t   strb;
    int unsigned req;
    insn_id_t    id;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk_i = ~clk_i;

  vrf_write_arbiter #(.NrReq(NrReq), .NrBank(NrBank)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid),
    .req_gnt_o      (req_gnt),
    .req_wdata_i    (req_wdata),
    .req_wstrb_i    (req_wstrb),
    .req_addr_i     (req_addr),
    .req_id_i       (req_id),
    .bank_rd_busy_i (bank_rd_busy),
    .bank_we_o      (bank_we),
    .bank_addr_o    (bank_addr),
    .bank_wdata_o   (bank_wdata),
    .bank_wstrb_o   (bank_wstrb),
    .wr_ack_o       (wr_ack),
    .wr_ack_id_o    (wr_ack_id)
  );

  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard: writes expected in this cycle are popped in bank order.
  always @(posedge clk_i) begin
    logic     [NrReq-1:0] exp_ack;
    insn_id_t [NrReq-1:0] exp_id;
    exp_t e;
    #2;
    exp_ack = '0;
    exp_id  = '0;
    for (int b = 0; b < NrBank; b++) begin
      n_cmp++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].bank == b) begin
        e = exp_q.pop_front();
        if (bank_we[b] !== 1'b1 || bank_addr[b] !== e.row || bank_wdata[b] !== e.data ||
            bank_wstrb[b] !== e.strb) begin
          n_err++;
          $display("FAIL write_bank%0d cyc=%0d: got we=%b addr=%h data=%h strb=%h, want we=1 addr=%h data=%h strb=%h",
                   b, cyc, bank_we[b], bank_addr[b], bank_wdata[b], bank_wstrb[b],
                   e.row, e.data, e.strb);
        end
        exp_ack[e.req] = 1'b1;
        exp_id[e.req]  = e.id;
      end else if (bank_we[b] !== 1'b0) begin
        n_err++;
        $display("FAIL spurious_we_bank%0d cyc=%0d: got we=%b, want 0", b, cyc, bank_we[b]);
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_write cyc=%0d: got no write, want bank%0d row=%h from r%0d",
               cyc, e.bank, e.row, e.req);
    end
    n_cmp++;
    if (wr_ack !== exp_ack) begin
      n_err++;
      $display("FAIL wr_ack cyc=%0d: got %b, want %b", cyc, wr_ack, exp_ack);
    end
    for (int r = 0; r < NrReq; r++) begin
      if (exp_ack[r]) begin
        n_cmp++;
        if (wr_ack_id[r] !== exp_id[r]) begin
          n_err++;
          $display("FAIL wr_ack_id r%0d cyc=%0d: got %0d, want %0d", r, cyc, wr_ack_id[r],
                   exp_id[r]);
        end
      end
    end
  end

  task automatic drive_req(input int r, input vrf_addr_t addr, input vrf_data_t data,
                           input vrf_strb_t strb, input insn_id_t id);
    req_valid[r] = 1'b1;
    req_addr[r]  = addr;
    req_wdata[r] = data;
    req_wstrb[r] = strb;
    req_id[r]    = id;
  endtask

  // Expected write from the stimulus the bench itself drove for requester r.
  task automatic push_write(input int r);
    exp_t e;
    e.cyc  = cyc + 1;
    e.bank = int'(req_addr[r][1:0]);
    e.row  = req_addr[r] >> 2;
    e.data = req_wdata[r];
    e.strb = req_wstrb[r];
    e.req  = r;
    e.id   = req_id[r];
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (bank_we !== '0 || wr_ack !== '0 || req_gnt !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got we=%b ack=%b gnt=%b, want all 0", bank_we, wr_ack, req_gnt);
    end
    n_cmp++;
    if (bank_addr !== '0 || bank_wdata !== '0 || bank_wstrb !== '0 || wr_ack_id !== '0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h data=%h strb=%h id=%h, want all 0",
               bank_addr, bank_wdata, bank_wstrb, wr_ack_id);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk_i);
    drive_req(0, 10'h005, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 3'd3);
    #1;
    n_cmp++;
    if (req_gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL single_gnt: got %b, want 0001", req_gnt);
    end
    push_write(0);
    @(negedge clk_i);
    req_valid = '0;
  endtask

  task automatic test_fairness();
    logic [NrReq-1:0] want;
    @(negedge clk_i);
    for (int r = 0; r < NrReq; r++) begin
      drive_req(r, vrf_addr_t'((r << 2) | 2), 64'hF00D_0000_0000_0000 | 64'(r), 8'h0F << r,
                insn_id_t'(r + 4));
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      want = 4'b0001 << (k % 4);
      n_cmp++;
      if (req_gnt !== want) begin
        n_err++;
        $display("FAIL fairness_gnt step%0d: got %b, want %b", k, req_gnt, want);
      end
      push_write(k % 4);
    end
    @(negedge clk_i);
    req_valid = '0;
  endtask

  task automatic test_parallel();
    @(negedge clk_i);
    drive_req(0, 10'h010, 64'h1111_0000_0000_0000, 8'h01, 3'd0);
    drive_req(1, 10'h021, 64'h2222_0000_0000_0001, 8'h03, 3'd1);
    drive_req(2, 10'h032, 64'h3333_0000_0000_0002, 8'h07, 3'd2);
    drive_req(3, 10'h043, 64'h4444_0000_0000_0003, 8'h80, 3'd7);
    #1;
    n_cmp++;
    if (req_gnt !== 4'b1111) begin
      n_err++;
      $display("FAIL parallel_gnt: got %b, want 1111", req_gnt);
    end
    for (int r = 0; r < NrReq; r++) push_write(r);
    @(negedge clk_i);
    req_valid = '0;
  endtask

  task automatic test_read_priority();
    logic [NrReq-1:0] want;
    @(negedge clk_i);
    bank_rd_busy = 4'b0010;
    drive_req(2, 10'h00D, 64'hBEEF_0000_CAFE_0002, 8'hF0, 3'd5);
    drive_req(0, 10'h007, 64'h0707_0707_0707_0707, 8'h3C, 3'd6);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk_i);
      if (k == 1) req_valid[0] = 1'b0;
      if (k == 3) bank_rd_busy = '0;
      #1;
      want = (k == 0) ? 4'b0001 : (k == 3) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (req_gnt !== want) begin
        n_err++;
        $display("FAIL rd_priority_gnt step%0d: got %b, want %b", k, req_gnt, want);
      end
      if (k == 0) push_write(0);
      if (k == 3) push_write(2);
    end
    @(negedge clk_i);
    req_valid = '0;
  endtask

  task automatic test_rr_hold();
    @(negedge clk_i);
    drive_req(1, 10'h008, 64'h5151_5151_0000_0001, 8'hFF, 3'd1);
    #1;
    n_cmp++;
    if (req_gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL rr_prime_gnt: got %b, want 0010", req_gnt);
    end
    push_write(1);
    @(negedge clk_i);
    req_valid = '0;
    drive_req(0, 10'h000, 64'h6060_6060_0000_0000, 8'h11, 3'd2);
    drive_req(3, 10'h00C, 64'h6363_6363_0000_0003, 8'h22, 3'd3);
    #1;
    n_cmp++;
    if (req_gnt !== 4'b1000) begin
      n_err++;
      $display("FAIL rr_hold_gnt: got %b, want 1000", req_gnt);
    end
    push_write(3);
    @(negedge clk_i);
    #1;
    n_cmp++;
    if (req_gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL rr_wrap_gnt: got %b, want 0001", req_gnt);
    end
    push_write(0);
    @(negedge clk_i);
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    drive_req(1, 10'h00A, 64'hDEAD_DEAD_DEAD_0001, 8'hFF, 3'd4);
    #1;
    n_cmp++;
    if (req_gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL reset_mid_gnt: got %b, want 0010", req_gnt);
    end
    @(posedge clk_i);
    #1;
    rst_ni    = 1'b0;
    req_valid = '0;
    #2;
    n_cmp++;
    if (bank_we !== '0 || wr_ack !== '0 || bank_addr !== '0 || bank_wdata !== '0 ||
        bank_wstrb !== '0 || wr_ack_id !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got we=%b ack=%b addr=%h data=%h, want all 0",
               bank_we, wr_ack, bank_addr, bank_wdata);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    // Retained pointers would pick r3 on bank 0 and r2 on bank 2.
    @(negedge clk_i);
    drive_req(0, 10'h010, 64'h0A0A_0000_0000_0000, 8'h01, 3'd1);
    drive_req(1, 10'h002, 64'h0B0B_0000_0000_0001, 8'h02, 3'd2);
    drive_req(2, 10'h006, 64'h0C0C_0000_0000_0002, 8'h04, 3'd3);
    drive_req(3, 10'h004, 64'h0D0D_0000_0000_0003, 8'h08, 3'd4);
    #1;
    n_cmp++;
    if (req_gnt !== 4'b0011) begin
      n_err++;
      $display("FAIL reset_rr_gnt: got %b, want 0011", req_gnt);
    end
    push_write(0);
    push_write(1);
    @(negedge clk_i);
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_parallel();
    test_read_priority();
    test_rr_hold();
    test_reset_mid();
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d writes outstanding, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vrf_write_arbiter.md
# vrf_write_arbiter

Lane-local VRF write-back arbiter: accepts result write requests from the lane's functional units (ALU and others) over the valid/gnt result interface, arbitrates per VRF bank with round-robin fairness, and drives the banked VRF SRAM write ports through one registered write stage. A VFU pops its result buffer and advances its write address on `req_gnt_o`. This block is the consumer side of that handshake. It also returns a per-requester write acknowledgement once the SRAM write is performed.

## Interface
- `NrReq`, 4: number of write requesters (VFUs); power of two, ≥2.
- `NrBank`, 4: number of VRF banks; power of two, ≥2. `LogNrBank = $clog2(NrBank)`.
- Types `vrf_data_t`, `vrf_strb_t`, `vrf_addr_t`, `insn_id_t` come from `core_pkg`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in [NrReq]: requester r holds a write.
- `req_gnt_o` out [NrReq]: write accepted this cycle; combinational.
- `req_wdata_i` in [NrReq] `vrf_data_t`: write data.
- `req_wstrb_i` in [NrReq] `vrf_strb_t`: byte strobes.
- `req_addr_i` in [NrReq] `vrf_addr_t`: VRF word address.
- `req_id_i` in [NrReq] `insn_id_t`: instruction id.
- `bank_rd_busy_i` in [NrBank]: operand read owns bank b's port next cycle.
- `bank_we_o` out [NrBank]: SRAM write enable.
- `bank_addr_o` out [NrBank] `vrf_addr_t`: row address, `req_addr >> LogNrBank`.
- `bank_wdata_o` out [NrBank] `vrf_data_t`; `bank_wstrb_o` out [NrBank] `vrf_strb_t`.
- `wr_ack_o` out [NrReq]: requester r's granted write was performed in this cycle.
- `wr_ack_id_o` out [NrReq] `insn_id_t`: id of the acknowledged write.

## Operation
- Bank select: `bank(r) = req_addr_i[r][LogNrBank-1:0]`.
- Per bank b, the candidates are requesters with `req_valid_i[r]` and `bank(r)==b`. If `bank_rd_busy_i[b]` is high, there is no grant for b (reads have priority). Otherwise exactly one candidate is granted. Selection is the first candidate at or after `rr_q[b]`, scanning upward modulo NrReq.
- Each requester targets one bank, so it receives at most one grant per cycle. Grants to different banks happen in parallel in the same cycle.
- On a grant to r at bank b: `rr_q[b] <= (r+1) mod NrReq`. Wrap: r=NrReq-1 gives 0. A bank with no grant keeps its `rr_q`.
- Write stage register per bank captures `we`, row address, wdata, wstrb, requester index and id from the granting cycle.
- The ack register per requester is loaded from the write stage. `wr_ack_o[r]` and `bank_we_o[b]` rise in the same cycle.
- No state machine beyond `rr_q` and the stage registers. There is no backpressure from SRAM: a granted write always completes next cycle.
- `req_valid_i` must not depend on `req_gnt_o` (no combinational loop). Requester data must be stable while valid and not granted.

## Timing
- Grant latency 0: `req_gnt_o` in the same cycle as `req_valid_i` when the bank is free and r wins.
- Write latency 1: a grant in cycle t gives `bank_we_o`/`bank_addr_o`/`bank_wdata_o`/`bank_wstrb_o` in t+1 and `wr_ack_o`/`wr_ack_id_o` in t+1.
- `bank_rd_busy_i[b]` in cycle t blocks grants in t, so a write never collides with the read using the port in t+1.
- Throughput: one write per bank per cycle. N requesters on one bank take N consecutive cycles, served in round-robin order.
- Reset values: `rr_q`=0, `bank_we_o`=0, `bank_addr_o`/`bank_wdata_o`/`bank_wstrb_o`=0, `wr_ack_o`=0, `wr_ack_id_o`=0.
- Reset mid-operation: any write held in the stage register is dropped (no `bank_we_o`, no ack). `req_gnt_o` during reset equals the combinational function of its inputs with `rr_q`=0. Requesters are also reset, so their valids are low.
- Simultaneous events: a grant in t and a stage write in t to the same bank are legal and pipelined. The stage reloads every cycle, and `we`=0 when there is no grant.

## Test plan
- Single write: r0 valid with addr=0x05, NrBank=4 (bank 1, row 1), data=0xA5.., id=3. Expect `req_gnt_o[0]`=1 same cycle. Next cycle expect `bank_we_o[1]`=1, `bank_addr_o[1]`=1, wdata/wstrb match, `wr_ack_o[0]`=1 with id 3.
- Conflict and fairness: r0..r3 all hold valid to bank 2 continuously. Grants go r0, r1, r2, r3, r0 (wrap) in consecutive cycles, with exactly one `bank_we_o[2]` per cycle.
- Parallel banks: r0→bank0, r1→bank1, r2→bank2, r3→bank3 in the same cycle. All four grants, and all four `bank_we_o` high the next cycle.
- Read priority: `bank_rd_busy_i[1]`=1 for 3 cycles while r2 requests bank 1. No grant for 3 cycles; grant in the 4th, write in the 5th. Other banks are unaffected.
- Round-robin hold: set `rr_q[0]`=2 via a prior grant to r1. r0 and r3 then request bank 0 together: r3 wins, and `rr_q[0]` becomes 0.
- Reset mid-write: grant r1 in cycle t, assert `rst_ni`=0 in t+1. Expect no `bank_we_o` and no `wr_ack_o`, all outputs 0, and `rr_q` at 0 after release.
